// File: rtl/store_drain_buffer_pkg.sv
// Shared types for the committed-store drain buffer: size encodings, FSM states,
// entry layout and the alignment rule.
package store_drain_buffer_pkg;

  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_MRG,
    ST_WR
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } store_entry_t;

  // The unused size code 2'b11 is treated as misaligned so it can never reach the RAM.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return (addr_lo != 2'b00);
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational read-modify-write merge: drops a right-aligned byte/half into
// its lane of the old RAM word; a word store replaces the whole word.
module store_lane_merge
  import store_drain_buffer_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_merged
);

  // NOTE: o_merged gets a full default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    o_merged = i_old_word;
    case (i_size)
      SIZE_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8]     = i_data[7:0];
      SIZE_HALF: o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_data[15:0];
      SIZE_WORD: o_merged = i_data;
      default:   o_merged = i_old_word;
    endcase
  end

endmodule

// File: rtl/store_drain_buffer.sv
// Committed-store FIFO that drains into a word-wide data RAM, doing a
// read-modify-write for byte/half stores and flagging load address conflicts.
module store_drain_buffer
  import store_drain_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] commit_addr,
  input  logic [31:0] commit_data,
  input  logic [1:0]  commit_size,
  output logic        commit_ready,
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        chk_valid,
  input  logic [31:0] chk_addr,
  output logic        chk_hit,
  output logic        empty,
  output logic        misalign_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  store_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_e        r_state;
  state_e        w_state_next;
  logic [31:0]   r_merged;

  store_entry_t  w_head;
  logic [31:0]   w_head_word_addr;
  logic [31:0]   w_merged;
  logic          w_head_misaligned;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_unused_chk_lo;

  assign w_head            = r_mem[r_rd_ptr];
  assign w_head_word_addr  = {w_head.addr[31:2], 2'b00};
  assign w_head_misaligned = is_misaligned(w_head.size, w_head.addr[1:0]);
  assign commit_ready      = (r_count != FULL_COUNT);
  assign w_push            = commit_valid && commit_ready;
  assign empty             = (r_count == '0) && (r_state == ST_IDLE);
  assign w_unused_chk_lo   = chk_addr[1:0];

  // NOTE: the entry array carries no reset; r_count qualifies every read of it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{addr: commit_addr, data: commit_data, size: commit_size};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_state  <= ST_IDLE;
      r_merged <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (r_state == ST_MRG) r_merged <= w_merged;
    end
  end

  store_lane_merge u_merge (
    .i_old_word (ram_rdata),
    .i_data     (w_head.data),
    .i_size     (w_head.size),
    .i_addr_lo  (w_head.addr[1:0]),
    .o_merged   (w_merged)
  );

  // RAM strobes are decoded from the state alone, so an async reset kills them at once.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    ram_re       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    misalign_err = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          if (w_head_misaligned) begin
            w_pop        = 1'b1;
            misalign_err = 1'b1;
          end else if (w_head.size == SIZE_WORD) begin
            w_state_next = ST_WR;
          end else begin
            w_state_next = ST_RD;
          end
        end
      end
      ST_RD: begin
        ram_re       = 1'b1;
        ram_addr     = w_head_word_addr;
        w_state_next = ST_MRG;
      end
      ST_MRG: begin
        w_state_next = ST_WR;
      end
      ST_WR: begin
        ram_we       = 1'b1;
        ram_addr     = w_head_word_addr;
        ram_wdata    = (w_head.size == SIZE_WORD) ? w_head.data : r_merged;
        w_pop        = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The draining head stays in the FIFO until its write completes, so it is covered here.
  always_comb begin
    chk_hit = 1'b0;
    if (chk_valid) begin
      if (w_push && (commit_addr[31:2] == chk_addr[31:2])) chk_hit = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < r_count) && (r_mem[r_rd_ptr + PW'(i)].addr[31:2] == chk_addr[31:2])) begin
          chk_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Bench for store_drain_buffer: directed scenarios plus random traffic, scored
// against a queue-based model of drain order, timing, RAM contents and conflicts.
module tb_store_drain_buffer;
  import store_drain_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic [31:0] commit_data;
  logic [1:0]  commit_size;
  logic        commit_ready;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        chk_valid;
  logic [31:0] chk_addr;
  logic        chk_hit;
  logic        empty;
  logic        misalign_err;

  store_drain_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_data  (commit_data),
    .commit_size  (commit_size),
    .commit_ready (commit_ready),
    .ram_re       (ram_re),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .chk_valid    (chk_valid),
    .chk_addr     (chk_addr),
    .chk_hit      (chk_hit),
    .empty        (empty),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          misal;
    bit          sub;
    logic [31:0] addr;
    logic [31:0] data;
    int          re_cyc;
    int          fin_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [29:0] pend_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] ram_mem   [logic [31:0]];

  int n_checks     = 0;
  int n_pass       = 0;
  int cyc          = 0;
  int accepted_cnt = 0;
  int retire_cnt   = 0;
  int last_final   = -10;
  int misal_seen   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: event not expected by the model (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Data RAM: one-cycle read latency; read data is junk except the cycle after ram_re.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] = ram_wdata;
    if (ram_re) ram_rdata <= ram_rd(ram_addr);
    else        ram_rdata <= $urandom;
  end

  // Reference model: apply each accepted store to model memory in order and predict
  // when its read, write or discard appears on the RAM side.
  task automatic accept(input logic [31:0] a, input logic [31:0] dat, input logic [1:0] s,
                        input int k);
    exp_t        e;
    logic [31:0] wa;
    logic [31:0] old;
    logic [31:0] nw;
    int          sh;
    int          d0;
    wa      = {a[31:2], 2'b00};
    e.misal = ((s == SIZE_HALF) && a[0]) || ((s == SIZE_WORD) && (a[1:0] != 2'b00));
    e.sub   = (s != SIZE_WORD);
    e.addr  = wa;
    old     = model_rd(wa);
    if (s == SIZE_BYTE) begin
      sh = 8 * int'(a[1:0]);
      nw = (old & ~(32'hFF << sh)) | ((dat & 32'hFF) << sh);
    end else if (s == SIZE_HALF) begin
      sh = a[1] ? 16 : 0;
      nw = (old & ~(32'hFFFF << sh)) | ((dat & 32'hFFFF) << sh);
    end else begin
      nw = dat;
    end
    if (!e.misal) model_mem[wa] = nw;
    e.data    = nw;
    d0        = (k > last_final + 1) ? k : last_final + 1;
    e.re_cyc  = d0 + 1;
    e.fin_cyc = d0 + (e.misal ? 0 : (e.sub ? 3 : 1));
    last_final = e.fin_cyc;
    sb_q.push_back(e);
    pend_q.push_back(a[31:2]);
    accepted_cnt++;
  endtask

  // Monitor: compares every RAM-side event against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_re || ram_we || misalign_err) fail_now("activity_in_reset");
    end else begin
      if (ram_re && ram_we) fail_now("re_and_we_together");
      if (ram_re) begin
        if (sb_q.size() == 0) fail_now("unexpected_ram_re");
        else if (!sb_q[0].sub || sb_q[0].misal) fail_now("ram_re_for_non_subword_head");
        else begin
          check("re_addr", ram_addr, sb_q[0].addr);
          check("re_cycle", cyc, sb_q[0].re_cyc);
        end
      end
      if (ram_we || misalign_err) begin
        if (sb_q.size() == 0) fail_now("unexpected_drain");
        else begin
          mon_e = sb_q.pop_front();
          pend_q.delete(0);
          retire_cnt++;
          if (misalign_err) misal_seen++;
          check("drain_kind_misalign", misalign_err, mon_e.misal);
          if (ram_we) begin
            check("wr_addr", ram_addr, mon_e.addr);
            check("wr_data", ram_wdata, mon_e.data);
          end
          check("drain_cycle", cyc, mon_e.fin_cyc);
        end
      end
    end
  end

  // One cycle of stimulus, called just after a rising edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] dat,
                      input logic [1:0] s, input logic cv, input logic [31:0] ca);
    int   mcount;
    logic exp_ready;
    logic hit;
    mcount    = accepted_cnt - retire_cnt;
    exp_ready = (mcount < DEPTH);
    check("commit_ready", commit_ready, exp_ready);
    check("empty", empty, (mcount == 0));
    commit_valid = v;
    commit_addr  = a;
    commit_data  = dat;
    commit_size  = s;
    chk_valid    = cv;
    chk_addr     = ca;
    hit = 1'b0;
    if (cv) begin
      foreach (pend_q[i]) if (pend_q[i] == ca[31:2]) hit = 1'b1;
      if (v && exp_ready && (a[31:2] == ca[31:2])) hit = 1'b1;
    end
    #1;
    check("chk_hit", chk_hit, hit);
    if (v && exp_ready) accept(a, dat, s, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input logic cv, input logic [31:0] ca);
    step(1'b0, 32'h0, 32'h0, SIZE_BYTE, cv, ca);
  endtask

  task automatic drain_wait();
    int budget;
    budget = 300;
    while ((accepted_cnt != retire_cnt) && (budget > 0)) begin
      idle_step(1'b0, 32'h0);
      budget--;
    end
    if (accepted_cnt != retire_cnt) fail_now("drain_timeout");
    idle_step(1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_commit_ready", commit_ready, 1'b1);
    check("rst_ram_re", ram_re, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_misalign_err", misalign_err, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_chk_hit", chk_hit, 1'b0);
  endtask

  task automatic model_clear();
    sb_q.delete();
    pend_q.delete();
    accepted_cnt = 0;
    retire_cnt   = 0;
    last_final   = -10;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int          m0;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] ca;
    rst          = 1'b0;
    commit_valid = 1'b0;
    commit_addr  = '0;
    commit_data  = '0;
    commit_size  = '0;
    chk_valid    = 1'b1;
    chk_addr     = 32'h100;
    model_mem[32'h200] = 32'h1122_3344;
    ram_mem[32'h200]   = 32'h1122_3344;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Word store into an empty buffer.
    step(1'b1, 32'h100, 32'hDEAD_BEEF, SIZE_WORD, 1'b0, 32'h0);
    drain_wait();
    check("word_in_ram", ram_rd(32'h100), 32'hDEAD_BEEF);

    // Byte store merged into an existing RAM word.
    step(1'b1, 32'h203, 32'h0000_00AB, SIZE_BYTE, 1'b0, 32'h0);
    drain_wait();
    check("byte_merge_in_ram", ram_rd(32'h200), 32'hAB22_3344);

    // Misaligned half is discarded, the following word drains normally.
    m0 = misal_seen;
    step(1'b1, 32'h301, 32'h0000_5555, SIZE_HALF, 1'b0, 32'h0);
    step(1'b1, 32'h304, 32'hCAFE_F00D, SIZE_WORD, 1'b0, 32'h0);
    drain_wait();
    check("misalign_pulses", misal_seen - m0, 1);
    check("misaligned_not_written", ram_rd(32'h300), init_word(32'h300));

    // Load conflict queries around a pending store.
    step(1'b1, 32'h400, 32'h0000_0077, SIZE_BYTE, 1'b1, 32'h402);
    idle_step(1'b1, 32'h402);
    idle_step(1'b1, 32'h404);
    drain_wait();
    idle_step(1'b1, 32'h402);

    // Fill behind slow byte stores; offers while full must be ignored.
    for (int i = 0; i < DEPTH + 6; i++) begin
      step(1'b1, 32'h600 + 32'(i), 32'(i * 17 + 3), SIZE_BYTE, 1'b0, 32'h0);
    end
    drain_wait();

    // Reset while the first of three byte stores is in its merge cycle.
    step(1'b1, 32'h5000, 32'h11, SIZE_BYTE, 1'b0, 32'h0);
    step(1'b1, 32'h5004, 32'h22, SIZE_BYTE, 1'b0, 32'h0);
    step(1'b1, 32'h5008, 32'h33, SIZE_BYTE, 1'b0, 32'h0);
    commit_valid = 1'b0;
    chk_valid    = 1'b1;
    chk_addr     = 32'h5000;
    rst          = 1'b0;
    model_clear();
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drain_wait();

    // Random traffic in a small window so conflicts and merges overlap.
    for (int n = 0; n < 400; n++) begin
      s = 2'($urandom_range(0, 2));
      a = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
      if (s == SIZE_BYTE || $urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(0, 3));
      else if (s == SIZE_HALF) a[1] = 1'($urandom_range(0, 1));
      ca = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      step(($urandom_range(0, 99) < 60), a, $urandom, s, 1'($urandom_range(0, 1)), ca);
    end
    drain_wait();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
